fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage of the 8-bit pipelined processor; feeds the decode stage.
//  - Owns the PC and drives the instruction-memory address.
//  - Captures the fetched instruction into the IF/ID pipeline register.
//  - Honours decode-side stall and execute-side redirect (branch/jump); stops fetching on HALT.
// PARAMETERS
//  PC_W         8      PC / imem address width
//  INSTR_W      8      instruction width
//  RESET_PC     8'h00  PC value after reset
//  NOP_INSTR    8'h00  encoding injected as a bubble
//  HALT_OPCODE  8'hFF  instruction encoding that halts fetch
// PORTS
//  clk            in   1        clock; all state updates on rising edge
//  reset          in   1        synchronous, active-high reset
//  stall_i        in   1        hazard unit: hold PC and IF/ID this cycle
//  redirect_i     in   1        taken branch/jump from execute
//  redirect_pc_i  in   PC_W     branch/jump target
//  imem_addr_o    out  PC_W     instruction-memory address (= PC, combinational)
//  imem_data_i    in   INSTR_W  instruction at imem_addr_o, same cycle (async ROM)
//  ifid_instr_o   out  INSTR_W  IF/ID instruction
//  ifid_pc_o      out  PC_W     PC of ifid_instr_o
//  ifid_valid_o   out  1        IF/ID holds a real instruction (0 = bubble)
//  halted_o       out  1        fetch FSM is in HALT
// BEHAVIOUR
//  Reset (sampled at rising edge, overrides all inputs):
//   pc=RESET_PC, ifid_instr=NOP_INSTR, ifid_pc=0, ifid_valid=0, FSM=RUN, halted_o=0.
//  imem_addr_o = pc at all times; no register between pc and imem_addr_o.
//  FSM states RUN, HALT. halted_o = (state==HALT), registered.
//  Priority per edge: reset > redirect_i > stall_i > normal/halt action.
//  redirect_i=1 (any state, stall_i ignored):
//   pc<=redirect_pc_i; ifid_instr<=NOP_INSTR; ifid_valid<=0; ifid_pc<=pc; state<=RUN.
//  RUN, stall_i=1: pc, ifid_* and state all hold.
//  RUN, no stall, imem_data_i!=HALT_OPCODE:
//   ifid_instr<=imem_data_i; ifid_pc<=pc; ifid_valid<=1; pc<=pc+1 mod 2^PC_W (0xFF->0x00).
//  RUN, no stall, imem_data_i==HALT_OPCODE:
//   ifid_instr<=HALT_OPCODE; ifid_pc<=pc; ifid_valid<=1; pc holds; state<=HALT.
//  HALT, stall_i=1: everything holds.
//  HALT, no stall: pc holds; ifid_instr<=NOP_INSTR; ifid_valid<=0; state stays HALT.
//  Only reset or redirect_i leaves HALT.
//  Latency: instruction at address A appears on ifid_* one edge after pc==A with stall_i=0.
//  Throughput: one instruction per cycle in RUN with no stall and no redirect.
//  Redirect: exactly one bubble; target instruction reaches IF/ID on the following edge.
//  No X propagation: every register is assigned on every reset edge.
// TESTING
//  1 Reset, ROM[0..3]=11,22,33,44, no stall -> ifid_instr 11,22,33,44 on edges 1-4.
//    ifid_pc 0,1,2,3; ifid_valid=1 throughout.
//  2 stall_i high for 2 cycles while pc=2 -> pc stays 2; ifid holds 22/pc 1 for both.
//    Then 33 on the next edge after stall_i falls.
//  3 redirect_i with target 0x40 while pc=3 -> next edge: ifid_valid=0, ifid_instr=00, pc=0x40.
//    Following edge: ifid_instr=ROM[0x40], ifid_pc=0x40.
//  4 redirect_i and stall_i high together -> redirect wins; pc=target; ifid_valid=0.
//  5 ROM[5]=FF -> ifid_instr=FF, valid=1, halted_o=1; pc stays 5; later edges give bubbles.
//    redirect_i to 0x10 -> halted_o=0; fetch resumes at 0x10.
//  6 pc=0xFF, ROM[0xFF]=12 -> ifid_pc=FF, pc wraps to 0x00.
//    reset asserted mid-stream -> all outputs at reset values on that edge.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives imem, fills IF/ID.
// Handles decode stall, execute redirect and HALT.
module fetch_stage #(
  parameter int PC_W = 8,
  parameter int INSTR_W = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
  parameter logic [INSTR_W-1:0] HALT_OPCODE = '1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [PC_W-1:0]    redirect_pc_i,
  output logic [PC_W-1:0]    imem_addr_o,
  input  logic [INSTR_W-1:0] imem_data_i,
  output logic [INSTR_W-1:0] ifid_instr_o,
  output logic [PC_W-1:0]    ifid_pc_o,
  output logic               ifid_valid_o,
  output logic               halted_o
);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic               valid;
  } if_id_t;

  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_HALT = 1'b1;

  logic [0:0]      state;
  logic [PC_W-1:0] pc;
  if_id_t          ifid;

  logic in_run;
  logic is_halt;
  logic do_fetch;
  logic do_halt;
  logic do_idle;

  assign in_run   = (state == S_RUN);
  assign is_halt  = (imem_data_i == HALT_OPCODE);
  assign do_fetch = in_run && !is_halt;
  assign do_halt  = in_run && is_halt;
  assign do_idle  = !in_run;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= RESET_PC;
      ifid.instr <= NOP_INSTR;
      ifid.pc    <= '0;
      ifid.valid <= 1'b0;
      state      <= S_RUN;
    end else if (redirect_i) begin
      // Redirect squashes the in-flight fetch, leaving one bubble.
      pc         <= redirect_pc_i;
      ifid.instr <= NOP_INSTR;
      ifid.pc    <= pc;
      ifid.valid <= 1'b0;
      state      <= S_RUN;
    end else if (!stall_i) begin
      unique case (1'b1)
        do_fetch: begin
          ifid.instr <= imem_data_i;
          ifid.pc    <= pc;
          ifid.valid <= 1'b1;
          pc         <= pc + 1'b1;
        end
        do_halt: begin
          ifid.instr <= HALT_OPCODE;
          ifid.pc    <= pc;
          ifid.valid <= 1'b1;
          state      <= S_HALT;
        end
        do_idle: begin
          ifid.instr <= NOP_INSTR;
          ifid.valid <= 1'b0;
        end
        default: begin
          ifid.valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_addr_o  = pc;
  assign ifid_instr_o = ifid.instr;
  assign ifid_pc_o    = ifid.pc;
  assign ifid_valid_o = ifid.valid;
  assign halted_o     = (state == S_HALT);

endmodule
